prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the instruction-memory interface.
- Receives a byte stream, for example from the UART receiver, and assembles little-endian 32-bit words.
- Writes the words sequentially into the instruction RAM write port starting at word address 0. The fetch unit reads the same RAM by word address.
- Holds the CPU in reset while loading and releases it only after a verified image has been written.

Parameters:
- ADDR_W, 14, word-address width of the instruction RAM (16K words, byte address bits [15:2]).
- LEN_W, 16, width of the image word-count header field.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader accepts the byte; a transfer occurs when rx_valid and rx_ready are both 1 on a posedge.
- imem_we  out  1  instruction RAM write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  1 forces the CPU/fetch unit into reset.
- busy  out  1  load in progress.
- done  out  1  last load completed with a good checksum.
- error  out  1  last load aborted (bad length or checksum).
- word_count  out  LEN_W  words written in the current or last load.

Behaviour:
- Image format, in byte order:
  - LEN_LO, LEN_HI: word count N, little-endian.
  - 4N data bytes, each word little-endian (first byte -> bits [7:0]).
  - One checksum byte = XOR of all 4N data bytes. The length bytes are excluded.
- Reset values: all outputs 0, state IDLE, except cpu_hold = 0.
- State machine (registered state; outputs decoded from state and registered datapath):
  - IDLE: rx_ready=0. On start -> LEN_LO. Clear word_count, address counter, byte index, checksum, done and error.
  - LEN_LO: rx_ready=1. On transfer, latch the low byte -> LEN_HI.
  - LEN_HI: rx_ready=1. On transfer, latch the high byte.
    - If N > 2^ADDR_W -> ERR.
    - If N == 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: rx_ready=1. Each transfer shifts the byte into lane [byte_idx] and XORs it into the checksum.
    - On the 4th byte, register imem_wdata/imem_addr and assert imem_we for exactly the next cycle.
    - Then increment the address and word_count.
    - When word_count reaches N -> CSUM.
  - CSUM: rx_ready=1. On transfer, compare with the running XOR. Equal -> DONE, else -> ERR.
  - DONE: done=1, cpu_hold=0, rx_ready=0. start -> LEN_LO (new load).
  - ERR: error=1, cpu_hold=1, rx_ready=0. start -> LEN_LO (retry); only reset or a good load releases the CPU.
- cpu_hold=1 and busy=1 in LEN_LO, LEN_HI, DATA and CSUM.
- Write latency: imem_we is high in the cycle after the posedge that accepted the 4th byte of a word. It is never high for two consecutive cycles, because at least 4 transfers are needed per word.
- Address: starts at 0 and increments by 1 per word. Address 2^ADDR_W-1 is the last writable word. N = 2^ADDR_W is legal and does not wrap.
- start while busy: ignored.
- rx_valid while rx_ready=0: the byte is not consumed, and no state change occurs.
- Reset mid-load: the next posedge returns to IDLE and drops cpu_hold, busy and imem_we. Partially written RAM contents are left as-is.
- start and reset in the same cycle: reset wins.

Decomposition:
- Shared package prog_loader_pkg holds:
  - State enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR).
  - Byte-lane index type.
  - Default ADDR_W/LEN_W constants, which the fetch unit also uses for its ROM address slice.
- One natural sub-module: prog_word_packer. It does byte-to-word assembly with byte_idx, lane shift and the word-complete strobe. The FSM, counters and checksum stay in the top.

Test Plan:
- Reset, then start; send 01 00 78 56 34 12 08 -> one imem_we pulse with addr=0, wdata=32'h12345678; then done=1, cpu_hold=0, word_count=1.
- Load N=3 with words 0x00000001, 0x00000002, 0x00000003 and checksum 0x00 -> writes at addr 0,1,2 in order; done=1.
- Same image with checksum 0xFF -> error=1, cpu_hold stays 1, done=0.
- Header N=0x4001 (ADDR_W=14) -> ERR immediately after LEN_HI, with no imem_we pulse.
- rx_valid toggled randomly (gaps of 0–5 cycles) on a 2-word image -> identical writes; rx_ready is 0 only outside the load states.
- Reset asserted after 2 data bytes of a load -> next cycle IDLE, cpu_hold=0, busy=0, no write. A following start with a full image completes normally.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader and its consumers.
package prog_loader_pkg;

    // Default instruction RAM geometry; the fetch unit slices its ROM address with the same value.
    localparam int ADDR_W_DEF = 14;
    localparam int LEN_W_DEF  = 16;

    // Loader states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    // Byte lane within a 32-bit little-endian word.
    typedef logic [1:0] lane_idx_t;

    // States in which a load is in progress and bytes are consumed.
    function automatic logic is_load_state(input state_e s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/prog_word_packer.sv
// Assembles four little-endian bytes into a 32-bit word and flags the completing byte.
module prog_word_packer
    import prog_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    lane_idx_t   byte_idx_q, byte_idx_d;
    logic [23:0] lanes_q, lanes_d;

    // The fourth byte is not stored: it is merged combinationally into the completed word.
    always_comb begin
        byte_idx_d = byte_idx_q;
        lanes_d    = lanes_q;
        if (clear_i) begin
            byte_idx_d = '0;
            lanes_d    = '0;
        end else if (byte_valid_i) begin
            byte_idx_d = byte_idx_q + lane_idx_t'(1);
            case (byte_idx_q)
                2'd0:    lanes_d[7:0]   = byte_i;
                2'd1:    lanes_d[15:8]  = byte_i;
                2'd2:    lanes_d[23:16] = byte_i;
                default: lanes_d        = lanes_q;
            endcase
        end
    end

    // Lane index and partial-word storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx_q <= '0;
            lanes_q    <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            lanes_q    <= lanes_d;
        end
    end

    assign word_o       = {byte_i, lanes_q};
    assign word_valid_o = byte_valid_i && (byte_idx_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Writes a length/data/checksum byte image into instruction RAM and holds the CPU until it verifies.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  word_count
);

    // Largest legal word count: the whole RAM, address 0 .. 2^ADDR_W-1.
    localparam logic [63:0] MAX_WORDS = 64'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              xfer;
    logic              start_ok;
    logic [LEN_W-1:0]  len_hdr;
    logic [31:0]       word;
    logic              word_valid;
    logic              last_word;

    assign xfer      = rx_valid && rx_ready;
    assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign len_hdr   = LEN_W'({rx_data, len_q[7:0]});
    assign last_word = word_valid && ((wcnt_q + LEN_W'(1)) == len_q);

    prog_word_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (start_ok),
        .byte_valid_i (xfer && (state_q == ST_DATA)),
        .byte_i       (rx_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; the length check is done on the full header as the high byte arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_LEN_LO;
            ST_LEN_LO: if (xfer) state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (xfer) begin
                    if (64'(len_hdr) > MAX_WORDS) state_d = ST_ERR;
                    else if (len_hdr == '0)       state_d = ST_CSUM;
                    else                          state_d = ST_DATA;
                end
            end
            ST_DATA: if (last_word) state_d = ST_CSUM;
            ST_CSUM: if (xfer) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state; a failed image keeps the CPU held.
    always_comb begin
        rx_ready = is_load_state(state_q);
        busy     = is_load_state(state_q);
        cpu_hold = is_load_state(state_q) || (state_q == ST_ERR);
        done     = (state_q == ST_DONE);
        error    = (state_q == ST_ERR);
    end

    // Datapath next state: header latch, checksum, address/word counters and the write strobe.
    always_comb begin
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (start_ok) begin
            len_d  = '0;
            wcnt_d = '0;
            addr_d = '0;
            csum_d = '0;
        end else if (xfer) begin
            case (state_q)
                ST_LEN_LO: len_d = LEN_W'(rx_data);
                ST_LEN_HI: len_d = len_hdr;
                ST_DATA: begin
                    csum_d = csum_q ^ rx_data;
                    if (word_valid) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = word;
                        addr_d  = addr_q + ADDR_W'(1);
                        wcnt_d  = wcnt_q + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign word_count = wcnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: image table plus hand-written reset/ignore sequences.
module tb_prog_loader;

    localparam int ADDR_W = 14;
    localparam int LEN_W  = 16;
    localparam int NVEC   = 6;

    logic              clock;
    logic              reset;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [LEN_W-1:0]  word_count;

    prog_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Image bytes right-justified: byte i is bytes[8*(nb-1-i) +: 8]; expected word k is wd[32*k +: 32].
    typedef struct {
        int           nb;
        logic [127:0] bytes;
        int           maxgap;
        logic         exp_done;
        logic         exp_err;
        int           exp_nw;
        logic [127:0] wd;
        logic [15:0]  exp_wc;
    } vec_t;

    vec_t vecs [NVEC];

    // Write capture and write-strobe spacing check.
    logic [31:0]       wr_data [$];
    logic [ADDR_W-1:0] wr_addr [$];
    logic              prev_we = 1'b0;

    always @(negedge clock) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            chk("we_back_to_back", 32'(prev_we), 32'd0);
        end
        prev_we = imem_we;
        chk("rx_ready_vs_busy", 32'(rx_ready), 32'(busy));
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int  g;
        bit  ok;
        g  = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        ok = 1'b0;
        repeat (g) begin @(posedge clock); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clock);
            if (rx_ready) begin
                @(posedge clock); #1;
                ok = 1'b1;
            end
        end
        rx_valid = 1'b0;
        if (!ok) chk("rx_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input int k);
        wr_addr.delete();
        wr_data.delete();
        do_start();
        for (int i = 0; i < vecs[k].nb; i++)
            send_byte(vecs[k].bytes[8*(vecs[k].nb-1-i) +: 8], vecs[k].maxgap);
        @(negedge clock);
        chk($sformatf("v%0d_done", k), 32'(done), 32'(vecs[k].exp_done));
        chk($sformatf("v%0d_error", k), 32'(error), 32'(vecs[k].exp_err));
        chk($sformatf("v%0d_cpu_hold", k), 32'(cpu_hold), 32'(vecs[k].exp_err));
        chk($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
        chk($sformatf("v%0d_word_count", k), 32'(word_count), 32'(vecs[k].exp_wc));
        chk($sformatf("v%0d_nwrites", k), 32'(wr_addr.size()), 32'(vecs[k].exp_nw));
        for (int w = 0; w < wr_addr.size() && w < 4; w++) begin
            chk($sformatf("v%0d_addr%0d", k, w), 32'(wr_addr[w]), 32'(w));
            chk($sformatf("v%0d_data%0d", k, w), wr_data[w], vecs[k].wd[32*w +: 32]);
        end
    endtask

    initial begin
        // 1 word 0x12345678, checksum 78^56^34^12 = 08
        vecs[0] = '{nb: 7, bytes: 128'h01_00_78_56_34_12_08, maxgap: 0, exp_done: 1'b1, exp_err: 1'b0,
                    exp_nw: 1, wd: 128'h12345678, exp_wc: 16'd1};
        // 3 words 1,2,3, checksum 00 (with small gaps)
        vecs[1] = '{nb: 15, bytes: 128'h03_00_01000000_02000000_03000000_00, maxgap: 2, exp_done: 1'b1,
                    exp_err: 1'b0, exp_nw: 3, wd: {32'h3, 32'h2, 32'h1}, exp_wc: 16'd3};
        // same image, bad checksum FF: words still written, load fails
        vecs[2] = '{nb: 15, bytes: 128'h03_00_01000000_02000000_03000000_FF, maxgap: 0, exp_done: 1'b0,
                    exp_err: 1'b1, exp_nw: 3, wd: {32'h3, 32'h2, 32'h1}, exp_wc: 16'd3};
        // N = 0x4001, one past the RAM size
        vecs[3] = '{nb: 2, bytes: 128'h01_40, maxgap: 0, exp_done: 1'b0, exp_err: 1'b1,
                    exp_nw: 0, wd: 128'h0, exp_wc: 16'd0};
        // 2 words with random gaps 0..5, checksum 22^44 = 66
        vecs[4] = '{nb: 11, bytes: 128'h02_00_EF_BE_AD_DE_44_33_22_11_66, maxgap: 5, exp_done: 1'b1,
                    exp_err: 1'b0, exp_nw: 2, wd: {32'h11223344, 32'hDEADBEEF}, exp_wc: 16'd2};
        // N = 0: header goes straight to checksum of nothing
        vecs[5] = '{nb: 3, bytes: 128'h00_00_00, maxgap: 0, exp_done: 1'b1, exp_err: 1'b0,
                    exp_nw: 0, wd: 128'h0, exp_wc: 16'd0};

        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clock); #1;
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        @(posedge clock); #1;

        for (int k = 0; k < NVEC; k++) run_vec(k);

        // In DONE, offered bytes are not consumed and nothing changes
        wr_addr.delete();
        rx_valid = 1'b1; rx_data = 8'hAA;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("done_rx_ready", 32'(rx_ready), 32'd0);
        chk("done_hold_done", 32'(done), 32'd1);
        chk("done_hold_busy", 32'(busy), 32'd0);
        chk("done_no_write", 32'(wr_addr.size()), 32'd0);
        @(posedge clock); #1;
        rx_valid = 1'b0;

        // Reset after 2 data bytes; start while busy is ignored
        wr_addr.delete();
        wr_data.delete();
        do_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h78, 0); send_byte(8'h56, 0);
        do_start();
        @(negedge clock);
        chk("midload_busy", 32'(busy), 32'd1);
        chk("midload_hold", 32'(cpu_hold), 32'd1);
        chk("midload_wc", 32'(word_count), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hold", 32'(cpu_hold), 32'd0);
        chk("midrst_we", 32'(imem_we), 32'd0);
        chk("midrst_no_write", 32'(wr_addr.size()), 32'd0);
        @(posedge clock); #1;
        run_vec(0);

        // N = 2^ADDR_W is accepted; then start and reset together: reset wins
        do_start();
        send_byte(8'h00, 0); send_byte(8'h40, 0);
        @(negedge clock);
        chk("maxn_busy", 32'(busy), 32'd1);
        chk("maxn_error", 32'(error), 32'd0);
        @(posedge clock); #1;
        start = 1'b1; reset = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; reset = 1'b0;
        @(negedge clock);
        chk("rst_start_busy", 32'(busy), 32'd0);
        chk("rst_start_hold", 32'(cpu_hold), 32'd0);
        chk("rst_start_error", 32'(error), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
